// File: rtl/sdram_prefetch_buffer_if.sv
// -----------------------------------------------------------------------------
// sdram_prefetch_buffer_if
//
// Request/response bus shared by the upstream (Wishbone-to-SDRAM adapter) side
// and the sdram_controller user port. Both sides use the same handshake, which
// lets the prefetch buffer drop in between them unchanged.
//
// Signals:
//   addr      byte address (ADDR_W bits)
//   rw        1 = write, 0 = read
//   data_in   write data (32 bits)
//   mask      byte enables for writes (bit i enables byte i)
//   in_valid  request strobe; accepted when in_valid=1 and busy=0
//   busy      responder cannot accept a request this cycle
//   data_out  read data
//   out_valid one-cycle read-data pulse
//
// Modports:
//   master  issues requests (drives addr/rw/data_in/mask/in_valid)
//   slave   serves requests (drives busy/data_out/out_valid)
// -----------------------------------------------------------------------------
interface sdram_prefetch_buffer_if #(
   parameter int ADDR_W = 23
);
   logic [ADDR_W-1:0] addr;
   logic              rw;
   logic [31:0]       data_in;
   logic [3:0]        mask;
   logic              in_valid;
   logic              busy;
   logic [31:0]       data_out;
   logic              out_valid;

   modport master (
      output addr, rw, data_in, mask, in_valid,
      input  busy, data_out, out_valid
   );

   modport slave (
      input  addr, rw, data_in, mask, in_valid,
      output busy, data_out, out_valid
   );
endinterface

// File: rtl/sdram_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// sdram_prefetch_buffer
//
// Single-line read-prefetch buffer placed between the Wishbone-to-SDRAM adapter
// and the sdram_controller user port. A read miss fetches the whole aligned
// line (2^LINE_LOG2 sequential 32-bit words, ascending from the line base,
// one controller read outstanding at a time). Reads that hit the line answer
// one cycle after acceptance. Writes are write-through: always forwarded to
// the controller, and merged into the buffered line on a hit so the line
// never goes stale.
//
// Parameters:
//   ADDR_W     byte address width on both ports (default 23)
//   LINE_LOG2  log2 of words per line (default 2 -> 4 words / 16 bytes)
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   up          upstream bus (slave side of sdram_prefetch_buffer_if)
//   ctrl        controller bus (master side of sdram_prefetch_buffer_if)
//   invalidate  clears the buffered line (deferred to IDLE if busy)
//   hit_count   saturating count of accepted read hits
//   miss_count  saturating count of accepted read misses
//
// Optional build macro:
//   SDRAM_PREFETCH_STATS_EN  when defined, hit_count/miss_count are live
//                            16-bit saturating counters; otherwise both are
//                            tied to zero and no counter logic exists.
// -----------------------------------------------------------------------------
module sdram_prefetch_buffer #(
   parameter int ADDR_W    = 23,
   parameter int LINE_LOG2 = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   sdram_prefetch_buffer_if.slave  up,
   sdram_prefetch_buffer_if.master ctrl,
   input  logic                    invalidate,
   output logic [15:0]             hit_count,
   output logic [15:0]             miss_count
);

   localparam int WORDS = 1 << LINE_LOG2;
   localparam int TAG_W = ADDR_W - LINE_LOG2 - 2;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_HIT_RSP   = 3'd1;
   localparam logic [2:0] S_WR_FWD    = 3'd2;
   localparam logic [2:0] S_FILL_REQ  = 3'd3;
   localparam logic [2:0] S_FILL_WAIT = 3'd4;
   localparam logic [2:0] S_MISS_RSP  = 3'd5;

   localparam logic [LINE_LOG2-1:0] LAST_IDX = LINE_LOG2'(WORDS - 1);

   // ---------------------------------------------------------------- state
   logic [2:0]           state_q,         state_d;
   logic                 valid_q,         valid_d;
   logic                 inv_pend_q,      inv_pend_d;
   logic [TAG_W-1:0]     tag_q,           tag_d;
   logic [LINE_LOG2-1:0] req_idx_q,       req_idx_d;
   logic [LINE_LOG2-1:0] cnt_q,           cnt_d;
   logic [31:0]          line_q [WORDS];
   logic [31:0]          line_d [WORDS];

   logic                 up_out_valid_q,  up_out_valid_d;
   logic [31:0]          up_data_out_q,   up_data_out_d;

   logic [ADDR_W-1:0]    ctrl_addr_q,     ctrl_addr_d;
   logic                 ctrl_rw_q,       ctrl_rw_d;
   logic [31:0]          ctrl_data_in_q,  ctrl_data_in_d;
   logic [3:0]           ctrl_mask_q,     ctrl_mask_d;
   logic                 ctrl_in_valid_q, ctrl_in_valid_d;

   // --------------------------------------------------------------- decode
   logic [TAG_W-1:0]     up_tag;
   logic [LINE_LOG2-1:0] up_idx;
   logic                 up_hit;
   logic                 up_busy_w;
   logic                 up_accept;
   logic                 ctrl_accept;
   logic                 last_word;
   logic [LINE_LOG2-1:0] cnt_inc;
   logic [31:0]          wr_merge;
   logic [31:0]          resp_word;
   logic [1:0]           unused_addr_lsb;

   assign up_tag          = up.addr[ADDR_W-1:LINE_LOG2+2];
   assign up_idx          = up.addr[LINE_LOG2+1:2];
   assign unused_addr_lsb = up.addr[1:0];
   assign up_hit          = valid_q && (up_tag == tag_q);
   assign up_busy_w       = (state_q != S_IDLE) || invalidate;
   assign up_accept       = up.in_valid && !up_busy_w;
   assign ctrl_accept     = ctrl_in_valid_q && !ctrl.busy;
   assign last_word       = (cnt_q == LAST_IDX);
   assign cnt_inc         = cnt_q + LINE_LOG2'(1);

   // Byte-wise merge of an incoming write into the buffered word it targets.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign wr_merge[8*gi +: 8] = up.mask[gi] ? up.data_in[8*gi +: 8]
                                                  : line_q[up_idx][8*gi +: 8];
      end
   endgenerate

   // When the requested word is the one arriving on the final beat it is not
   // in the array yet, so take it straight from the controller bus.
   assign resp_word = (req_idx_q == cnt_q) ? ctrl.data_out : line_q[req_idx_q];

   // ------------------------------------------------------------ next state
   always_comb begin
      state_d         = state_q;
      valid_d         = valid_q;
      inv_pend_d      = inv_pend_q;
      tag_d           = tag_q;
      req_idx_d       = req_idx_q;
      cnt_d           = cnt_q;
      line_d          = line_q;
      up_out_valid_d  = 1'b0;
      up_data_out_d   = up_data_out_q;
      ctrl_addr_d     = ctrl_addr_q;
      ctrl_rw_d       = ctrl_rw_q;
      ctrl_data_in_d  = ctrl_data_in_q;
      ctrl_mask_d     = ctrl_mask_q;
      ctrl_in_valid_d = ctrl_in_valid_q;

      case (state_q)
         S_IDLE: begin
            if (invalidate) begin
               valid_d = 1'b0;
            end else if (up_accept) begin
               if (up.rw) begin
                  ctrl_addr_d     = {up.addr[ADDR_W-1:2], 2'b00};
                  ctrl_rw_d       = 1'b1;
                  ctrl_data_in_d  = up.data_in;
                  ctrl_mask_d     = up.mask;
                  ctrl_in_valid_d = 1'b1;
                  if (up_hit) begin
                     line_d[up_idx] = wr_merge;
                  end
                  state_d = S_WR_FWD;
               end else if (up_hit) begin
                  up_out_valid_d = 1'b1;
                  up_data_out_d  = line_q[up_idx];
                  state_d        = S_HIT_RSP;
               end else begin
                  tag_d           = up_tag;
                  req_idx_d       = up_idx;
                  valid_d         = 1'b0;
                  cnt_d           = '0;
                  ctrl_addr_d     = {up_tag, {LINE_LOG2{1'b0}}, 2'b00};
                  ctrl_rw_d       = 1'b0;
                  ctrl_mask_d     = 4'b0000;
                  ctrl_in_valid_d = 1'b1;
                  state_d         = S_FILL_REQ;
               end
            end
         end

         S_HIT_RSP: begin
            state_d = S_IDLE;
         end

         S_WR_FWD: begin
            if (ctrl_accept) begin
               ctrl_in_valid_d = 1'b0;
               state_d         = S_IDLE;
            end
         end

         S_FILL_REQ: begin
            if (ctrl_accept) begin
               ctrl_in_valid_d = 1'b0;
               state_d         = S_FILL_WAIT;
            end
         end

         S_FILL_WAIT: begin
            if (ctrl.out_valid) begin
               line_d[cnt_q] = ctrl.data_out;
               if (last_word) begin
                  valid_d        = 1'b1;
                  up_out_valid_d = 1'b1;
                  up_data_out_d  = resp_word;
                  state_d        = S_MISS_RSP;
               end else begin
                  cnt_d           = cnt_inc;
                  ctrl_addr_d     = {tag_q, cnt_inc, 2'b00};
                  ctrl_in_valid_d = 1'b1;
                  state_d         = S_FILL_REQ;
               end
            end
         end

         S_MISS_RSP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // An invalidate seen outside IDLE is remembered and takes effect on the
      // way back to IDLE, so a line filled under it never becomes valid.
      if (state_q != S_IDLE) begin
         if (invalidate) begin
            inv_pend_d = 1'b1;
         end
         if (state_d == S_IDLE) begin
            if (inv_pend_q || invalidate) begin
               valid_d = 1'b0;
            end
            inv_pend_d = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         valid_q         <= 1'b0;
         inv_pend_q      <= 1'b0;
         tag_q           <= '0;
         req_idx_q       <= '0;
         cnt_q           <= '0;
         up_out_valid_q  <= 1'b0;
         up_data_out_q   <= '0;
         ctrl_addr_q     <= '0;
         ctrl_rw_q       <= 1'b0;
         ctrl_data_in_q  <= '0;
         ctrl_mask_q     <= '0;
         ctrl_in_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         valid_q         <= valid_d;
         inv_pend_q      <= inv_pend_d;
         tag_q           <= tag_d;
         req_idx_q       <= req_idx_d;
         cnt_q           <= cnt_d;
         up_out_valid_q  <= up_out_valid_d;
         up_data_out_q   <= up_data_out_d;
         ctrl_addr_q     <= ctrl_addr_d;
         ctrl_rw_q       <= ctrl_rw_d;
         ctrl_data_in_q  <= ctrl_data_in_d;
         ctrl_mask_q     <= ctrl_mask_d;
         ctrl_in_valid_q <= ctrl_in_valid_d;
      end
   end

   // Line data needs no reset: it is only read while valid_q is set, and
   // valid_q is only set once every word has been refilled.
   always_ff @(posedge clk) begin
      line_q <= line_d;
   end

   // --------------------------------------------------------------- outputs
   assign up.busy        = up_busy_w;
   assign up.data_out    = up_data_out_q;
   assign up.out_valid   = up_out_valid_q;

   assign ctrl.addr      = ctrl_addr_q;
   assign ctrl.rw        = ctrl_rw_q;
   assign ctrl.data_in   = ctrl_data_in_q;
   assign ctrl.mask      = ctrl_mask_q;
   assign ctrl.in_valid  = ctrl_in_valid_q;

   // ------------------------------------------------------------ statistics
`ifdef SDRAM_PREFETCH_STATS_EN
   logic        rd_hit_acc;
   logic        rd_miss_acc;
   logic [15:0] hit_cnt_q,  hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   assign rd_hit_acc  = (state_q == S_IDLE) && up_accept && !up.rw && up_hit;
   assign rd_miss_acc = (state_q == S_IDLE) && up_accept && !up.rw && !up_hit;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (rd_hit_acc && (hit_cnt_q != 16'hFFFF)) begin
         hit_cnt_d = hit_cnt_q + 16'd1;
      end
      if (rd_miss_acc && (miss_cnt_q != 16'hFFFF)) begin
         miss_cnt_d = miss_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = 16'd0;
   assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_sdram_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_sdram_prefetch_buffer
//
// Table-driven bench for sdram_prefetch_buffer with a behavioural SDRAM
// controller model and a read-data scoreboard, plus hand-written sequences for
// controller back-pressure, invalidate during a fill and reset during a fill.
// -----------------------------------------------------------------------------
module tb_sdram_prefetch_buffer;
   localparam int ADDR_W = 23;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        invalidate = 1'b0;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   sdram_prefetch_buffer_if #(.ADDR_W(ADDR_W)) up_if ();
   sdram_prefetch_buffer_if #(.ADDR_W(ADDR_W)) ctrl_if ();

   sdram_prefetch_buffer #(.ADDR_W(ADDR_W), .LINE_LOG2(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .up         (up_if),
      .ctrl       (ctrl_if),
      .invalidate (invalidate),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------- controller model
   logic [31:0] mem [logic [ADDR_W-1:0]];
   int resp_delay = 1;

   function automatic logic [31:0] mem_rd(input logic [ADDR_W-1:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'hF000_0000 | 32'(a);
   endfunction

   typedef struct {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        mask;
   } creq_t;

   creq_t clog[$];
   creq_t cr;
   logic [31:0] wword;

   initial begin
      ctrl_if.busy      = 1'b0;
      ctrl_if.out_valid = 1'b0;
      ctrl_if.data_out  = 32'd0;
      forever begin
         @(negedge clk);
         if (!rst && ctrl_if.in_valid && !ctrl_if.busy) begin
            cr.rw   = ctrl_if.rw;
            cr.addr = ctrl_if.addr;
            cr.data = ctrl_if.data_in;
            cr.mask = ctrl_if.mask;
            clog.push_back(cr);
            @(posedge clk); #1;
            if (cr.rw) begin
               wword = mem_rd(cr.addr);
               for (int b = 0; b < 4; b++)
                  if (cr.mask[b]) wword[8*b +: 8] = cr.data[8*b +: 8];
               mem[cr.addr] = wword;
            end else begin
               for (int k = 1; k < resp_delay; k++) begin
                  @(posedge clk); #1;
               end
               ctrl_if.data_out  = mem_rd(cr.addr);
               ctrl_if.out_valid = 1'b1;
               @(posedge clk); #1;
               ctrl_if.out_valid = 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------- scoreboard
   logic [31:0] sb[$];
   int resp_cnt      = 0;
   int last_resp_cyc = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && up_if.out_valid) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            if (sb.size() == 0) begin
               check("unexpected_rsp", 32'(sb.size()), 32'd1);
            end else begin
               check("rsp_data", up_if.data_out, sb.pop_front());
            end
            $display("rsp cyc=%0d data=0x%08h", cyc, up_if.data_out);
         end
      end
   end

   // ---------------------------------------------------------- helpers
   task automatic issue(input logic rw, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] data, input logic [3:0] mask,
                        output int req_cyc);
      int n;
      n = 0;
      up_if.rw       = rw;
      up_if.addr     = addr;
      up_if.data_in  = data;
      up_if.mask     = mask;
      up_if.in_valid = 1'b1;
      @(negedge clk);
      while (up_if.busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("issue_accept", 32'(up_if.busy), 32'd0);
      req_cyc = cyc;
      @(posedge clk); #1;
      up_if.in_valid = 1'b0;
   endtask

   task automatic wait_sb();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         n++;
         @(negedge clk); #1;
      end
      check("rsp_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (up_if.busy && n < 300) begin
         n++;
         @(negedge clk);
      end
      check("idle_timeout", 32'(up_if.busy), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_fill(input string name, input logic [ADDR_W-1:0] base);
      check({name, "_nreq"}, 32'(clog.size()), 32'd4);
      if (clog.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            check({name, "_addr"}, 32'(clog[k].addr), 32'(base) + 32'(4*k));
            check({name, "_rw"},   32'(clog[k].rw),   32'd0);
         end
      end
   endtask

   task automatic check_reset_vals();
      check("rst_up_busy",   32'(up_if.busy),       32'd0);
      check("rst_up_ov",     32'(up_if.out_valid),  32'd0);
      check("rst_up_data",   up_if.data_out,        32'd0);
      check("rst_ctrl_iv",   32'(ctrl_if.in_valid), 32'd0);
      check("rst_ctrl_rw",   32'(ctrl_if.rw),       32'd0);
      check("rst_ctrl_addr", 32'(ctrl_if.addr),     32'd0);
      check("rst_ctrl_mask", 32'(ctrl_if.mask),     32'd0);
      check("rst_ctrl_data", ctrl_if.data_in,       32'd0);
      check("rst_hit_cnt",   32'(hit_count),        32'd0);
      check("rst_miss_cnt",  32'(miss_count),       32'd0);
   endtask

   // ----------------------------------------------------------- vectors
   typedef struct {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        mask;
      logic              exp_hit;
      logic [31:0]       exp_data;
   } vec_t;

   vec_t vecs[12];
   int   req_cyc;
   int   exp_hits;
   int   exp_misses;
   int   resp_before;

   initial begin
      //            rw    addr      data           mask     hit   exp_data
      vecs[0]  = '{1'b0, 23'h104, 32'h0,        4'b0000, 1'b0, 32'h0000_0022};
      vecs[1]  = '{1'b0, 23'h10C, 32'h0,        4'b0000, 1'b1, 32'h0000_0044};
      vecs[2]  = '{1'b1, 23'h108, 32'hAABBCCDD, 4'b0011, 1'b1, 32'h0};
      vecs[3]  = '{1'b0, 23'h108, 32'h0,        4'b0000, 1'b1, 32'h0000_CCDD};
      vecs[4]  = '{1'b0, 23'h100, 32'h0,        4'b0000, 1'b1, 32'h0000_0011};
      vecs[5]  = '{1'b1, 23'h300, 32'h12345678, 4'b1111, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 23'h104, 32'h0,        4'b0000, 1'b1, 32'h0000_0022};
      vecs[7]  = '{1'b0, 23'h30C, 32'h0,        4'b0000, 1'b0, 32'h0000_00AC};
      vecs[8]  = '{1'b0, 23'h300, 32'h0,        4'b0000, 1'b1, 32'h1234_5678};
      vecs[9]  = '{1'b1, 23'h304, 32'hDEADBEEF, 4'b1000, 1'b1, 32'h0};
      vecs[10] = '{1'b0, 23'h304, 32'h0,        4'b0000, 1'b1, 32'hDE00_00A4};
      vecs[11] = '{1'b0, 23'h108, 32'h0,        4'b0000, 1'b0, 32'h0000_CCDD};

      mem[23'h100] = 32'h11; mem[23'h104] = 32'h22;
      mem[23'h108] = 32'h33; mem[23'h10C] = 32'h44;
      mem[23'h300] = 32'hA0; mem[23'h304] = 32'hA4;
      mem[23'h308] = 32'hA8; mem[23'h30C] = 32'hAC;

      up_if.rw = 1'b0; up_if.addr = '0; up_if.data_in = '0;
      up_if.mask = '0; up_if.in_valid = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      @(posedge clk); #1;
      rst = 1'b0;

      // ---- table
      exp_hits = 0; exp_misses = 0;
      for (int i = 0; i < 12; i++) begin
         clog.delete();
         if (!vecs[i].rw) begin
            sb.push_back(vecs[i].exp_data);
            if (vecs[i].exp_hit) exp_hits++; else exp_misses++;
         end
         issue(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].mask, req_cyc);
         if (vecs[i].rw) begin
            wait_idle();
            check("wr_nreq", 32'(clog.size()), 32'd1);
            if (clog.size() == 1) begin
               check("wr_addr", 32'(clog[0].addr), 32'(vecs[i].addr));
               check("wr_rw",   32'(clog[0].rw),   32'd1);
               check("wr_data", clog[0].data,      vecs[i].data);
               check("wr_mask", 32'(clog[0].mask), 32'(vecs[i].mask));
            end
         end else begin
            wait_sb();
            wait_idle();
            if (vecs[i].exp_hit) begin
               check("hit_nreq",    32'(clog.size()), 32'd0);
               check("hit_latency", 32'(last_resp_cyc - req_cyc), 32'd1);
            end else begin
               check_fill("miss", {vecs[i].addr[ADDR_W-1:4], 4'h0});
            end
         end
         $display("vec %0d rw=%0d addr=0x%06h ctrl_reqs=%0d", i, vecs[i].rw,
                  vecs[i].addr, clog.size());
      end
`ifdef SDRAM_PREFETCH_STATS_EN
      check("hit_count",  32'(hit_count),  32'(exp_hits));
      check("miss_count", 32'(miss_count), 32'(exp_misses));
`else
      check("hit_count",  32'(hit_count),  32'd0);
      check("miss_count", 32'(miss_count), 32'd0);
`endif

      // ---- controller busy for 5 cycles during FILL_REQ
      clog.delete();
      ctrl_if.busy = 1'b1;
      sb.push_back(mem_rd(23'h404));
      issue(1'b0, 23'h404, 32'h0, 4'h0, req_cyc);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_ctrl_iv",   32'(ctrl_if.in_valid), 32'd1);
         check("bp_ctrl_addr", 32'(ctrl_if.addr),     32'h400);
         check("bp_up_busy",   32'(up_if.busy),       32'd1);
      end
      @(posedge clk); #1;
      ctrl_if.busy = 1'b0;
      wait_sb();
      wait_idle();
      check_fill("bp", 23'h400);
      $display("seq busy: ctrl_reqs=%0d", clog.size());

      // ---- invalidate during FILL_WAIT of a miss on 0x200
      clog.delete();
      resp_delay = 4;
      sb.push_back(mem_rd(23'h200));
      issue(1'b0, 23'h200, 32'h0, 4'h0, req_cyc);
      @(posedge clk); #1;
      invalidate = 1'b1;
      @(posedge clk); #1;
      invalidate = 1'b0;
      resp_delay = 1;
      wait_sb();
      wait_idle();
      check_fill("inv_fill", 23'h200);
      clog.delete();
      sb.push_back(mem_rd(23'h200));
      issue(1'b0, 23'h200, 32'h0, 4'h0, req_cyc);
      wait_sb();
      wait_idle();
      check_fill("inv_reread", 23'h200);
      $display("seq inv-fill: reread ctrl_reqs=%0d", clog.size());

      // ---- invalidate while IDLE: busy for that cycle, line dropped
      invalidate = 1'b1;
      @(negedge clk);
      check("inv_idle_busy", 32'(up_if.busy), 32'd1);
      @(posedge clk); #1;
      invalidate = 1'b0;
      clog.delete();
      sb.push_back(mem_rd(23'h208));
      issue(1'b0, 23'h208, 32'h0, 4'h0, req_cyc);
      wait_sb();
      wait_idle();
      check_fill("inv_idle", 23'h200);
      $display("seq inv-idle: ctrl_reqs=%0d", clog.size());

      // ---- reset mid-fill followed by a stale controller return
      clog.delete();
      resp_delay = 6;
      issue(1'b0, 23'h500, 32'h0, 4'h0, req_cyc);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_reset_vals();
      @(posedge clk); #1;
      rst = 1'b0;
      resp_before = resp_cnt;
      repeat (12) @(posedge clk);
      #1;
      check("rst_no_rsp", 32'(resp_cnt - resp_before), 32'd0);
      check("rst_nreq",   32'(clog.size()), 32'd1);
      resp_delay = 1;
      clog.delete();
      sb.push_back(mem_rd(23'h500));
      issue(1'b0, 23'h500, 32'h0, 4'h0, req_cyc);
      wait_sb();
      wait_idle();
      check_fill("rst_reread", 23'h500);
      $display("seq rst-fill: reread ctrl_reqs=%0d", clog.size());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
